// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, feeding bytes and a new-data strobe
// to the accelerator load FSM; framing errors and state are exported for debug.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       RxD,
  output logic [7:0] RxData,
  output logic       isNewData,
  output logic       frameErr,
  output logic       isBusy,
  output logic [7:0] rxCount,
  output logic [1:0] state_tap
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic          s1;
  logic          s2;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign isBusy    = (state != IDLE);
  assign state_tap = state;

  // Synchroniser flops reset high so a reset never looks like a start edge on an idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s1        <= 1'b1;
      s2        <= 1'b1;
      prev      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      RxData    <= '0;
      isNewData <= 1'b0;
      frameErr  <= 1'b0;
      rxCount   <= '0;
    end else begin
      s1        <= RxD;
      s2        <= s1;
      prev      <= s2;
      isNewData <= 1'b0;
      frameErr  <= 1'b0;

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!s2 && prev) begin
              state <= START;
            end
          end

          START: begin
            if (cnt == HALF_LAST) begin
              cnt <= '0;
              if (!s2) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          DATA: begin
            if (cnt == BIT_LAST) begin
              cnt     <= '0;
              shreg   <= {s2, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STOP: begin
            if (cnt == BIT_LAST) begin
              cnt   <= '0;
              state <= IDLE;
              if (s2) begin
                RxData    <= shreg;
                isNewData <= 1'b1;
                rxCount   <= rxCount + 8'd1;
              end else begin
                frameErr <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: single frame, glitch,
// framing error, 256 back-to-back frames with count wrap, enable drop and reset.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       en;
  logic       RxD;
  logic [7:0] RxData;
  logic       isNewData;
  logic       frameErr;
  logic       isBusy;
  logic [7:0] rxCount;
  logic [1:0] state_tap;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ndCount = 0;
  int feCount = 0;
  int bothCount = 0;
  int lastNdCyc = 0;
  int lastFeCyc = 0;
  logic [7:0] ndQ[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .RxD(RxD),
    .RxData(RxData),
    .isNewData(isNewData),
    .frameErr(frameErr),
    .isBusy(isBusy),
    .rxCount(rxCount),
    .state_tap(state_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far when read at a falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder; counting per cycle makes a stretched pulse show up as an extra count.
  always @(negedge clk) begin
    if (isNewData) begin
      ndCount   <= ndCount + 1;
      lastNdCyc <= cyc;
      ndQ.push_back(RxData);
    end
    if (frameErr) begin
      feCount   <= feCount + 1;
      lastFeCyc <= cyc;
    end
    if (isNewData && frameErr) bothCount <= bothCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one frame starting at a falling edge; actKind 1 drops en, 2 pulses reset, at bit-time offset actAt.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int actAt, input int actKind, output int e0);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    e0 = cyc + 1;
    for (int j = 0; j < 10 * CPB; j++) begin
      RxD = frame[j / CPB];
      if (j == actAt) begin
        if (actKind == 1) begin
          checkOutput("en_drop_pre_state", 32'(state_tap), 32'd2);
          en = 1'b0;
        end else if (actKind == 2) begin
          checkOutput("reset_pre_state", 32'(state_tap), 32'd3);
          reset = 1'b1;
        end
      end
      @(negedge clk);
      if (j == actAt && actKind != 0) begin
        checkOutput("abort_state", 32'(state_tap), 32'd0);
        checkOutput("abort_busy", 32'(isBusy), 32'd0);
        checkOutput("abort_newdata", 32'(isNewData), 32'd0);
        checkOutput("abort_frameerr", 32'(frameErr), 32'd0);
        if (actKind == 2) begin
          checkOutput("reset_rxdata", 32'(RxData), 32'h00);
          checkOutput("reset_rxcount", 32'(rxCount), 32'd0);
          reset = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int e0;
    int ndBase;
    int feBase;

    reset = 1'b1;
    en    = 1'b0;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rxdata", 32'(RxData), 32'h00);
    checkOutput("rst_newdata", 32'(isNewData), 32'd0);
    checkOutput("rst_frameerr", 32'(frameErr), 32'd0);
    checkOutput("rst_busy", 32'(isBusy), 32'd0);
    checkOutput("rst_rxcount", 32'(rxCount), 32'd0);
    checkOutput("rst_state", 32'(state_tap), 32'd0);
    reset = 1'b0;
    en    = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 1'b1, -1, 0, e0);
    checkOutput("t1_nd_count", 32'(ndCount), 32'd1);
    checkOutput("t1_nd_cycle", 32'(lastNdCyc), 32'(e0 + 154));
    checkOutput("t1_rxdata", 32'(RxData), 32'hA5);
    checkOutput("t1_rxcount", 32'(rxCount), 32'd1);
    checkOutput("t1_fe_count", 32'(feCount), 32'd0);
    checkOutput("t1_busy_after", 32'(isBusy), 32'd0);

    $display("[TB] glitch rejection");
    repeat (CPB) @(negedge clk);
    RxD = 1'b0;
    e0 = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_idle_e1", 32'(state_tap), 32'd0);
    @(negedge clk);
    checkOutput("t2_start_e2", 32'(state_tap), 32'd1);
    checkOutput("t2_busy_e2", 32'(isBusy), 32'd1);
    @(negedge clk);
    RxD = 1'b1;
    while (cyc < e0 + 9) @(negedge clk);
    checkOutput("t2_start_e9", 32'(state_tap), 32'd1);
    @(negedge clk);
    checkOutput("t2_idle_e10", 32'(state_tap), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    checkOutput("t2_nd_count", 32'(ndCount), 32'd1);
    checkOutput("t2_fe_count", 32'(feCount), 32'd0);
    checkOutput("t2_rxdata", 32'(RxData), 32'hA5);

    $display("[TB] framing error then recovery");
    applyStimulus(8'h3C, 1'b0, -1, 0, e0);
    checkOutput("t3_fe_count", 32'(feCount), 32'd1);
    checkOutput("t3_fe_cycle", 32'(lastFeCyc), 32'(e0 + 154));
    checkOutput("t3_nd_count", 32'(ndCount), 32'd1);
    checkOutput("t3_rxdata", 32'(RxData), 32'hA5);
    checkOutput("t3_rxcount", 32'(rxCount), 32'd1);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("t3_held_low_state", 32'(state_tap), 32'd0);
    checkOutput("t3_held_low_busy", 32'(isBusy), 32'd0);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
    applyStimulus(8'h55, 1'b1, -1, 0, e0);
    checkOutput("t3_rxdata_55", 32'(RxData), 32'h55);
    checkOutput("t3_nd_count_55", 32'(ndCount), 32'd2);
    checkOutput("t3_nd_cycle_55", 32'(lastNdCyc), 32'(e0 + 154));
    checkOutput("t3_rxcount_55", 32'(rxCount), 32'd2);
    checkOutput("t3_fe_count_55", 32'(feCount), 32'd1);

    $display("[TB] 256 back-to-back frames");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t4_rxcount_start", 32'(rxCount), 32'd0);
    ndBase = ndCount;
    feBase = feCount;
    ndQ.delete();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 1'b1, -1, 0, e0);
    end
    checkOutput("t4_nd_count", 32'(ndCount - ndBase), 32'd256);
    checkOutput("t4_last_cycle", 32'(lastNdCyc), 32'(e0 + 154));
    for (int i = 0; i < 256; i++) begin
      logic [7:0] got;
      got = (i < ndQ.size()) ? ndQ[i] : 8'hxx;
      checkOutput("t4_data", 32'(got), 32'(i));
    end
    checkOutput("t4_rxcount_wrap", 32'(rxCount), 32'd0);
    checkOutput("t4_rxdata_last", 32'(RxData), 32'hFF);
    checkOutput("t4_fe_count", 32'(feCount - feBase), 32'd0);

    $display("[TB] enable drop and mid-frame reset");
    ndBase = ndCount;
    feBase = feCount;
    applyStimulus(8'hFF, 1'b1, 70, 1, e0);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("t5_en_nd_count", 32'(ndCount - ndBase), 32'd0);
    checkOutput("t5_en_fe_count", 32'(feCount - feBase), 32'd0);
    checkOutput("t5_en_rxdata", 32'(RxData), 32'hFF);
    checkOutput("t5_en_rxcount", 32'(rxCount), 32'd0);
    en = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h81, 1'b1, -1, 0, e0);
    checkOutput("t5_rxdata_81", 32'(RxData), 32'h81);
    checkOutput("t5_rxcount_81", 32'(rxCount), 32'd1);
    checkOutput("t5_nd_count_81", 32'(ndCount - ndBase), 32'd1);
    ndBase = ndCount;
    applyStimulus(8'h42, 1'b1, 148, 2, e0);
    repeat (3 * CPB) @(negedge clk);
    checkOutput("t5_rst_nd_count", 32'(ndCount - ndBase), 32'd0);
    checkOutput("t5_rst_fe_count", 32'(feCount - feBase), 32'd0);
    checkOutput("t5_rst_rxdata", 32'(RxData), 32'h00);
    checkOutput("t5_rst_rxcount", 32'(rxCount), 32'd0);
    checkOutput("t5_rst_state", 32'(state_tap), 32'd0);
    checkOutput("never_both_strobes", 32'(bothCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver that turns the serial `RxD` line into bytes for the DNN accelerator top. It recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) by mid-bit sampling. Each good byte is presented on `RxData` together with a one-cycle `isNewData` strobe. Those two outputs are the inputs the accelerator's load FSM consumes to fill its weight and data SIPO buffers. Framing errors and a debug state tap are also exported so they can be brought out on the logic-analyser bus.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200 baud). Must be even and ≥ 8.
- `HALF`, default `CLKS_PER_BIT/2`: local, derived from `CLKS_PER_BIT`; not overridable.

Ports:
- `clk`  input  1: the block's single clock. All logic is on its rising edge.
- `reset`  input  1: synchronous, active-high.
- `en`  input  1: receiver enable. Low forces IDLE and suppresses all strobes.
- `RxD`  input  1: asynchronous serial line; idles high.
- `RxData`  output  8: last good byte received. Held until the next good byte.
- `isNewData`  output  1: one-cycle pulse when `RxData` updates.
- `frameErr`  output  1: one-cycle pulse when the stop bit is sampled low.
- `isBusy`  output  1: high whenever state ≠ IDLE.
- `rxCount`  output  8: number of good bytes received; wraps modulo 256.
- `state_tap`  output  2: encoded state (IDLE=0, START=1, DATA=2, STOP=3).

## Operation
Input synchroniser:
- `RxD` passes through two flops, `s1` then `s2`.
- `prev` is a registered copy of `s2`.
- `s1`, `s2` and `prev` all reset to 1.

Counters:
- `cnt` is a bit-period counter sized for `CLKS_PER_BIT-1`.
- `bitIdx` is 3 bits wide.
- `shreg` is an 8-bit shift register that shifts right, inserting the sampled bit at bit 7.

State machine:
- **IDLE**
  - `cnt` = 0.
  - If `en`, `s2`=0 and `prev`=1 (falling edge), go to START with `cnt`=0.
  - A line held low never retriggers, because a falling edge is required.
- **START**
  - `cnt` increments each cycle.
  - At the edge where `cnt`=`HALF-1`, sample `s2`.
  - If 0: go to DATA, `cnt`=0, `bitIdx`=0.
  - If 1: the start was a glitch; go to IDLE with no output activity.
- **DATA**
  - At the edge where `cnt`=`CLKS_PER_BIT-1`, shift `s2` into `shreg`, clear `cnt` and increment `bitIdx`.
  - After the sample taken at `bitIdx`=7, go to STOP.
- **STOP**, at the edge where `cnt`=`CLKS_PER_BIT-1`, sample `s2`:
  - If 1: `RxData` ← `shreg`, `isNewData` ← 1, `rxCount` ← `rxCount`+1 (255 wraps to 0).
  - If 0: `frameErr` ← 1; `RxData` and `rxCount` are unchanged and there is no `isNewData`.
  - Either way, go to IDLE.

Strobes and enable:
- `isNewData` and `frameErr` are registered and high for exactly one cycle. They are never high together.
- If `en` goes low in any state, the next edge forces IDLE with `cnt`=0. Any partial byte is discarded. `RxData` and `rxCount` hold.

Reset:
- `reset` overrides `en` and all state activity.
- Mid-frame reset aborts the frame, with no strobe afterwards.
- The remainder of the aborted frame is ignored unless it contains a new high→low transition.

## Timing
- Reset values:
  - State IDLE, so `isBusy`=0 and `state_tap`=0.
  - `RxData`=0x00, `isNewData`=0, `frameErr`=0, `rxCount`=0.
  - `cnt`=0, `bitIdx`=0, `shreg`=0.
- Latency:
  - Let e0 be the first `clk` edge that samples `RxD` low.
  - START is entered at e0+2.
  - The start bit is sampled at e0+2+`HALF`.
  - Data bit k is sampled at e0+2+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at e0+2+`HALF`+9·`CLKS_PER_BIT`. `isNewData` (or `frameErr`) is high in the cycle following that edge.
  - With `CLKS_PER_BIT`=16 this is the edge e0+154.
- Back-to-back frames:
  - IDLE is re-entered at the stop-sample edge.
  - A start bit whose falling edge arrives ≥ `HALF` cycles after the nominal stop-bit start is received without loss.
- `isBusy` goes high the cycle after e0+2 and low the cycle after the stop-sample edge.

## Test plan
Tests use `CLKS_PER_BIT`=16.
1. **Single frame.** Reset, `en`=1, send 0xA5 at 16 clk/bit. Require `RxData`=0xA5 and `isNewData` high exactly one cycle after edge e0+154, `rxCount`=1, `frameErr` never high.
2. **Glitch rejection.** Drive `RxD` low for 4 cycles, then high. Require a return to IDLE at e0+10, no strobes, `RxData` unchanged.
3. **Framing error.** Send 0x3C with the stop bit low and the line held low afterwards. Require a one-cycle `frameErr` pulse, no `isNewData`, `RxData` still the previous value. Then release the line and send 0x55: require `RxData`=0x55 with no retrigger while the line was held low.
4. **Back-to-back and wrap.** Send 256 consecutive frames with no idle gap between them (byte value = index). Require 256 `isNewData` pulses with `RxData` matching each index, and `rxCount` ending at 0x00.
5. **Enable and reset mid-frame.** Drop `en` during data bit 3 of 0xFF: require IDLE next cycle and no strobe. Re-enable and send 0x81: require `RxData`=0x81. Assert `reset` during the stop bit of 0x42: require all outputs at reset values and no strobe.
